// File: rtl/bus_pkg.sv
// Shared definitions for the per-master bus request controller: FSM state
// encoding and default bus geometry.
package bus_pkg;

  localparam int AW_DEF = 8;   // bus address width
  localparam int DW_DEF = 32;  // bus data width
  localparam int LW_DEF = 4;   // burst-length field width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bus_master_ctrl.sv
// Per-master bus request controller. Accepts a burst command from the local
// core, requests the bus from the arbiter, issues one beat per granted cycle
// with an incrementing (wrapping) address, returns read data, and stalls in
// place whenever grant is withdrawn mid-burst.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wdata_in,
  output logic          wdata_ack,
  input  logic          grant,
  output logic          req,
  output logic          bus_en,
  output logic          bus_wr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done
);

  state_t        state_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] cnt_q;
  logic          req_r;
  logic          busy_r;
  logic          done_r;
  logic          rd_valid_r;
  logic [DW-1:0] rd_hold_r;
  logic          beat_s;
  logic          wr_beat_s;

  // Burst FSM; req/busy/done are registered alongside the state so they are
  // glitch-free decodes of the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (cmd_len != '0) begin
              wr_q    <= cmd_wr;
              addr_q  <= cmd_addr;
              cnt_q   <= cmd_len;
              req_r   <= 1'b1;
              state_q <= ST_REQ;
            end else begin
              // Null command completes without ever touching the arbiter.
              done_r  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (grant) begin
            state_q <= ST_XFER;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_XFER: begin
          if (grant) begin
            addr_q <= addr_q + AW'(1);
            cnt_q  <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              req_r   <= 1'b0;
              done_r  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_XFER;
            end
          end else begin
            // Grant withdrawn: hold address and count, keep requesting.
            state_q <= ST_XFER;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          req_r   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat qualification: a default or stale grant never drives the bus
  // unless this master is actually transferring.
  always_comb begin
    beat_s    = (state_q == ST_XFER) && grant;
    wr_beat_s = beat_s && wr_q;
  end

  // Bus drive; everything is zero when idle so masters can be OR-muxed.
  always_comb begin
    bus_en    = beat_s;
    bus_wr    = wr_beat_s;
    wdata_ack = wr_beat_s;
    if (beat_s) begin
      bus_addr = addr_q;
    end else begin
      bus_addr = '0;
    end
    if (wr_beat_s) begin
      bus_wdata = wdata_in;
    end else begin
      bus_wdata = '0;
    end
  end

  // Read return: slave data arrives the cycle after a read beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      rd_hold_r  <= '0;
    end else begin
      rd_valid_r <= beat_s && !wr_q;
      if (rd_valid_r) begin
        rd_hold_r <= bus_rdata;
      end else begin
        rd_hold_r <= rd_hold_r;
      end
    end
  end

  // Present live slave data in the valid cycle, last captured word otherwise.
  always_comb begin
    rd_valid = rd_valid_r;
    if (rd_valid_r) begin
      rd_data = bus_rdata;
    end else begin
      rd_data = rd_hold_r;
    end
  end

  // Registered status outputs.
  always_comb begin
    req  = req_r;
    busy = busy_r;
    done = done_r;
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: stimulus pushes expected beats,
// read words and completions into queues; a negedge monitor pops and checks.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wdata_in;
  logic        wdata_ack;
  logic        grant;
  logic        req;
  logic        bus_en;
  logic        bus_wr;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { int cyc; logic rdv; } done_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  done_t       done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beats_seen = 0;
  int wbeat    = 0;
  int exp_wbeat = 0;

  bus_master_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_in(wdata_in),
    .wdata_ack(wdata_ack), .grant(grant), .req(req), .bus_en(bus_en),
    .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core-side write data source: advances one word per acknowledged beat.
  always @(posedge clk) if (wdata_ack === 1'b1) wbeat <= wbeat + 1;
  assign wdata_in = 32'hC0DE_0000 + wbeat;

  // Slave model: registered read data tagged with the beat address.
  always @(posedge clk)
    bus_rdata <= (bus_en === 1'b1 && bus_wr === 1'b0) ? {16'hA5A5, 8'h00, bus_addr} : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an output.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus_en === 1'b1) begin
        beats_seen++;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {56'h0, bus_addr}, 64'hFFFF);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", {56'h0, bus_addr}, {56'h0, b.addr});
          chk("beat_wr", {63'h0, bus_wr}, {63'h0, b.wr});
          chk("beat_ack", {63'h0, wdata_ack}, {63'h0, b.wr});
          if (b.wr) chk("beat_wdata", {32'h0, bus_wdata}, {32'h0, b.wdata});
        end
      end else begin
        chk("idle_bus_zero", {22'h0, bus_wr, bus_addr, bus_wdata, wdata_ack}, 64'h0);
      end
      if (rd_valid === 1'b1) begin
        if (rd_q.size() == 0) chk("unexpected_rd", {32'h0, rd_data}, 64'hFFFF_FFFF_FFFF);
        else chk("rd_data", {32'h0, rd_data}, {32'h0, rd_q.pop_front()});
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'hFFFF);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("done_rd_valid", {63'h0, rd_valid}, {63'h0, d.rdv});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command in the current cycle; extra = expected grant-stall cycles.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [3:0] len, input int extra);
    int c;
    done_t d;
    c = cyc;
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      logic [7:0] a;
      a = addr + 8'(i);
      b.wr = wr;
      b.addr = a;
      b.wdata = 32'h0;
      if (wr) begin
        b.wdata = 32'hC0DE_0000 + exp_wbeat;
        exp_wbeat++;
      end else begin
        rd_q.push_back({16'hA5A5, 8'h00, a});
      end
      beat_q.push_back(b);
    end
    d.cyc = (len == 4'd0) ? c + 1 : c + int'(len) + 2 + extra;
    d.rdv = (len != 4'd0) && !wr;
    done_q.push_back(d);
    cmd_wr = wr; cmd_addr = addr; cmd_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until done is observed (bounded), leaving us in the DONE cycle.
  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 64'(n), 64'(max_cyc + 1));
  endtask

  initial begin
    reset_n = 1'b0; grant = 1'b1; start = 1'b0;
    cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_len = 4'd0;
    tick(); tick();
    // Reset with the default grant high: everything quiet.
    chk("rst_req_busy_done", {61'h0, req, busy, done}, 64'h0);
    chk("rst_bus", {22'h0, bus_en, bus_wr, bus_addr, wdata_ack, bus_wdata}, 64'h0);
    chk("rst_rd", {31'h0, rd_valid, rd_data}, 64'h0);
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_default_grant", {62'h0, bus_en, req}, 64'h0);

    // Write burst wrapping past 8'hFF, start pulse mid-burst must be ignored.
    issue(1'b1, 8'hFE, 4'd3, 0);
    tick();
    cmd_len = 4'd1; cmd_addr = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    tick();

    // Read burst, then back-to-back write in the cycle after DONE.
    issue(1'b0, 8'h10, 4'd2, 0);
    wait_done(20);
    tick();
    chk("b2b_idle", {62'h0, busy, req}, 64'h0);
    issue(1'b1, 8'h7F, 4'd1, 0);
    wait_done(20);
    tick();

    // Grant withdrawn for two cycles after beat 2.
    issue(1'b1, 8'h40, 4'd4, 2);
    tick(); tick(); tick();
    grant = 1'b0;
    #1;
    chk("drop1_req_en", {62'h0, req, bus_en}, 64'h2);
    tick();
    chk("drop2_req_en", {62'h0, req, bus_en}, 64'h2);
    chk("drop_pending", 64'(beat_q.size()), 64'd2);
    tick();
    grant = 1'b1;
    wait_done(20);
    tick();

    // Null command: immediate done, never requests.
    issue(1'b0, 8'h33, 4'd0, 0);
    chk("null_req_busy_done", {61'h0, req, busy, done}, 64'h3);
    tick();

    // Reset during beat 2 of a 5-beat write.
    issue(1'b1, 8'h80, 4'd5, 0);
    tick(); tick();
    chk("pre_reset_pending", 64'(beat_q.size()), 64'd4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", {60'h0, req, bus_en, busy, done}, 64'h0);
    chk("midrst_bus", {22'h0, bus_wr, bus_addr, wdata_ack, bus_wdata}, 64'h0);
    beat_q.delete();
    done_q.delete();
    exp_wbeat = wbeat;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    issue(1'b1, 8'h20, 4'd2, 0);
    wait_done(20);
    tick(); tick();

    chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    chk("total_beats", 64'(beats_seen), 64'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_master_ctrl.md
# bus_master_ctrl

Per-master bus request controller sitting directly upstream of the three-master arbiter: one instance per master drives that master's `mX_req` and consumes its `mX_grant`. It accepts a burst command from the local core, holds the request until granted, issues one bus beat per granted cycle with incrementing address, returns read data, and pauses without losing state whenever grant is withdrawn mid-burst.

## Interface
- `AW`, 8, bus address width
- `DW`, 32, bus data width
- `LW`, 4, burst-length field width (max burst 2^LW−1 beats)

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  AW  burst start address
- `cmd_len`  in  LW  beat count; 0 = null command
- `wdata_in`  in  DW  write data for the current beat
- `wdata_ack`  out  1  current `wdata_in` consumed this cycle
- `grant`  in  1  arbiter grant for this master (`mX_grant`)
- `req`  out  1  arbiter request (`mX_req`)
- `bus_en`  out  1  beat valid on shared bus
- `bus_wr`  out  1  beat direction
- `bus_addr`  out  AW  beat address
- `bus_wdata`  out  DW  beat write data
- `bus_rdata`  in  DW  slave read data, valid one cycle after a read beat
- `rd_valid`  out  1  `rd_data` valid
- `rd_data`  out  DW  captured read data
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, REQ, XFER, DONE.
- IDLE: `start`=1 with `cmd_len`≠0 → latch `cmd_wr`, `cmd_addr`, `cmd_len` into `wr_q`, `addr_q`, `cnt_q`; go REQ. `start` with `cmd_len`=0 → DONE directly (no request). `start` outside IDLE ignored.
- REQ: `req`=1. `grant`=1 at edge → XFER. No beat issued in REQ.
- XFER: `req`=1. Each cycle with `grant`=1: beat issued (`bus_en`=1), `addr_q`+1, `cnt_q`−1. `grant`=0: no beat, counters hold, stay XFER. Beat with `cnt_q`=1 → DONE.
- DONE: `req`=0, `done`=1 for exactly one cycle → IDLE.
- `req` = (state==REQ)|(state==XFER), registered-state decode, glitch-free.
- `bus_en` = (state==XFER) & `grant` (combinational on grant). Arbiter's grant defaults to m0 with no requests; the state gating guarantees a master never drives the bus on a default/stale grant.
- `bus_addr`=`addr_q`, `bus_wr`=`wr_q`; when `bus_en`=0 all bus outputs are 0 (outputs are ORed across masters).
- Write: `bus_wdata`=`wdata_in` and `wdata_ack`=`bus_en`&`wr_q`.
- Read: `rd_valid` registered = `bus_en`&~`wr_q` delayed one cycle; `rd_data` captures `bus_rdata` that cycle. Last read data appears in the DONE cycle.
- Address wraps modulo 2^AW; no boundary error.

## Timing
- Reset: state=IDLE; `req`, `bus_en`, `bus_wr`, `wdata_ack`, `rd_valid`, `busy`, `done` = 0; `bus_addr`, `bus_wdata`, `rd_data` = 0.
- `start` at edge N → `req`=1 from cycle N+1. Arbiter registers grant, so earliest first beat at N+2.
- Uncontended N-beat burst: `req` high N+1 cycles, `done` at cycle start+N+2.
- Grant lost mid-burst: zero beats lost or duplicated; resume at same `addr_q`.
- Reset asserted mid-burst: immediate return to reset values; partial burst discarded, no `done`.
- New `start` accepted in the cycle after DONE (back-to-back bursts re-arbitrate).

## Structure
- Shared package `bus_pkg`: state encoding (IDLE=2'd0, REQ=2'd1, XFER=2'd2, DONE=2'd3), default `AW`/`DW`/`LW`.
- Single flat module; no sub-module. Top-level integration instantiates three `bus_master_ctrl` plus the arbiter; bus OR-mux lives at top.

## Test plan
- Reset: `reset_n`=0 with `grant`=1 → all outputs 0, `req`=0, `bus_en`=0.
- Write burst `cmd_addr`=8'hFE, `cmd_len`=3, `grant` tied 1 from cycle after `req` → beats at 8'hFE, 8'hFF, 8'h00 on consecutive cycles, `wdata_ack` ×3, `done` one cycle later.
- Read burst len 2 at 8'h10, slave returns 32'hA5A5_0010/0011 → `rd_valid` two cycles, data matches, second in DONE cycle.
- Grant drop: len 4, `grant` deasserted for 2 cycles after beat 2 → `req` stays 1, `bus_en`=0 two cycles, beats 3-4 at addr+2, addr+3, total exactly 4 beats.
- Default-grant safety: IDLE with `grant`=1 (m0 default) → `bus_en`=0; `cmd_len`=0 start → `done` next cycle, `req` never asserted.
- `reset_n` low during beat 2 of len 5 → outputs clear asynchronously, no `done`; fresh start afterwards completes normally.
